// File: rtl/dram_stream_arbiter_pkg.sv
// Shared definitions for the DRAM stream arbiter: stream-type encoding,
// controller state enum and default sizing.
package sys_defs;

    localparam int DEF_NUM_PE = 4;
    localparam int DEF_LEN_W  = 16;

    typedef enum logic {
        STREAM_INPUT  = 1'b0,
        STREAM_FILTER = 1'b1
    } stream_type_e;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        STREAM,
        FINISH
    } arb_state_e;

    // Index width that stays legal for a single requester.
    function automatic int pe_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dram_stream_arbiter_rr_arbiter.sv
// Combinational round-robin selector: the first requester found walking
// upward from ptr (with wrap-around) wins.
module rr_arbiter #(
    parameter int NUM_PE = 4,
    parameter int PE_W   = 2
)(
    input  logic [NUM_PE-1:0] req,
    input  logic [PE_W-1:0]   ptr,
    output logic [PE_W-1:0]   grant,
    output logic              any
);

    always_comb begin
        logic [PE_W-1:0] idx;
        grant = '0;
        any   = 1'b0;
        idx   = '0;
        for (int i = 0; i < NUM_PE; i++) begin
            idx = PE_W'((int'(ptr) + i) % NUM_PE);
            if (!any && req[idx]) begin
                any   = 1'b1;
                grant = idx;
            end
        end
    end

endmodule

// File: rtl/dram_stream_arbiter.sv
// Grants one PE at a time a DRAM read burst of its latched length and type,
// streams beat indices with stall back-pressure and pulses a typed finish.
module dram_stream_arbiter
    import sys_defs::*;
#(
    parameter int  NUM_PE = DEF_NUM_PE,
    parameter int  LEN_W  = DEF_LEN_W,
    localparam int PE_W   = pe_idx_w(NUM_PE)
)(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_PE-1:0]       req_valid,
    input  logic [NUM_PE-1:0]       req_type,
    input  logic [NUM_PE*LEN_W-1:0] req_len,
    output logic [NUM_PE-1:0]       req_ready,
    input  logic                    mem_stall,
    output logic                    mem_rd_en,
    output logic                    mem_rd_type,
    output logic [LEN_W-1:0]        mem_rd_addr,
    output logic [PE_W-1:0]         mem_rd_pe,
    output logic [NUM_PE-1:0]       stream_input_finish,
    output logic [NUM_PE-1:0]       stream_filter_finish,
    output logic                    busy
);

    arb_state_e       state, state_nxt;
    logic [PE_W-1:0]  rr_ptr;
    logic [PE_W-1:0]  gnt_q;
    stream_type_e     type_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] cnt;
    logic [PE_W-1:0]  win_idx;
    logic             win_any;
    logic [LEN_W-1:0] win_len;
    logic             accept;

    function automatic logic [PE_W-1:0] next_ptr(input logic [PE_W-1:0] g);
        return (g == PE_W'(NUM_PE - 1)) ? '0 : g + PE_W'(1);
    endfunction

    rr_arbiter #(
        .NUM_PE (NUM_PE),
        .PE_W   (PE_W)
    ) u_rr_arbiter (
        .req    (req_valid),
        .ptr    (rr_ptr),
        .grant  (win_idx),
        .any    (win_any)
    );

    always_comb begin
        win_len = '0;
        for (int p = 0; p < NUM_PE; p++)
            if (win_idx == PE_W'(p))
                win_len = req_len[p*LEN_W +: LEN_W];
    end

    // Gated by rst so no acceptance pulse can escape while reset is held.
    assign accept = (state == IDLE) && win_any && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            rr_ptr <= '0;
            gnt_q  <= '0;
            type_q <= STREAM_INPUT;
            len_q  <= '0;
            cnt    <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                gnt_q  <= win_idx;
                type_q <= stream_type_e'(req_type[win_idx]);
                len_q  <= win_len;
            end
            if (state == GRANT)
                cnt <= '0;
            if (state == STREAM && !mem_stall)
                cnt <= cnt + LEN_W'(1);
            if (state == FINISH)
                rr_ptr <= next_ptr(gnt_q);
        end
    end

    always_comb begin
        state_nxt            = state;
        req_ready            = '0;
        mem_rd_en            = 1'b0;
        stream_input_finish  = '0;
        stream_filter_finish = '0;
        case (state)
            IDLE: begin
                if (accept) begin
                    req_ready[win_idx] = 1'b1;
                    state_nxt          = GRANT;
                end
            end
            GRANT: begin
                state_nxt = (len_q != '0) ? STREAM : FINISH;
            end
            STREAM: begin
                mem_rd_en = !mem_stall;
                // len_q is nonzero here, so len_q-1 never wraps.
                if (!mem_stall && cnt == len_q - LEN_W'(1))
                    state_nxt = FINISH;
            end
            FINISH: begin
                if (type_q == STREAM_FILTER)
                    stream_filter_finish[gnt_q] = 1'b1;
                else
                    stream_input_finish[gnt_q] = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy        = (state != IDLE);
    assign mem_rd_addr = cnt;
    assign mem_rd_type = type_q;
    assign mem_rd_pe   = gnt_q;

endmodule

// File: tb/tb_dram_stream_arbiter.sv
// Scoreboard bench for dram_stream_arbiter: a burst-level model predicts
// every acceptance, beat and finish event with its cycle; a monitor compares.
module tb_dram_stream_arbiter;

    localparam int NPE     = 4;
    localparam int LW      = 16;
    localparam int K_READY = 1;
    localparam int K_BEAT  = 2;
    localparam int K_FIN   = 3;

    logic              clk       = 1'b0;
    logic              rst       = 1'b1;
    logic [NPE-1:0]    req_valid = '0;
    logic [NPE-1:0]    req_type  = '0;
    logic [NPE*LW-1:0] req_len   = '0;
    logic              mem_stall = 1'b0;
    logic [NPE-1:0]    req_ready;
    logic              mem_rd_en;
    logic              mem_rd_type;
    logic [LW-1:0]     mem_rd_addr;
    logic [1:0]        mem_rd_pe;
    logic [NPE-1:0]    stream_input_finish;
    logic [NPE-1:0]    stream_filter_finish;
    logic              busy;

    dram_stream_arbiter #(.NUM_PE(NPE), .LEN_W(LW)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .req_valid            (req_valid),
        .req_type             (req_type),
        .req_len              (req_len),
        .req_ready            (req_ready),
        .mem_stall            (mem_stall),
        .mem_rd_en            (mem_rd_en),
        .mem_rd_type          (mem_rd_type),
        .mem_rd_addr          (mem_rd_addr),
        .mem_rd_pe            (mem_rd_pe),
        .stream_input_finish  (stream_input_finish),
        .stream_filter_finish (stream_filter_finish),
        .busy                 (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          checks    = 0;
    int          passes    = 0;
    int          model_ptr = 0;
    logic [63:0] expq[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act === expv) passes++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    endtask

    function automatic logic [63:0] word(input int kind, input int c, input logic [31:0] d);
        return {8'(kind), 24'(c), d};
    endfunction

    task automatic pop_cmp(input string name, input logic [63:0] act);
        if (expq.size() == 0) chk({"unexpected_", name}, act, 64'd0);
        else chk(name, act, expq.pop_front());
    endtask

    // Monitor: every output event must match the head of the expectation queue.
    always @(negedge clk) begin
        logic fin;
        logic ok;
        fin = ((stream_input_finish | stream_filter_finish) != '0);
        if (req_ready != '0)
            pop_cmp("ready", word(K_READY, cyc, {28'd0, req_ready}));
        if (mem_rd_en)
            pop_cmp("beat", word(K_BEAT, cyc, {6'd0, mem_rd_pe, 7'd0, mem_rd_type, mem_rd_addr}));
        if (fin)
            pop_cmp("finish", word(K_FIN, cyc, {24'd0, stream_filter_finish, stream_input_finish}));
        if (req_ready != '0 || mem_rd_en || fin) begin
            ok = ($countones({req_ready, stream_input_finish, stream_filter_finish}) <= 1)
                 && !(mem_rd_en && fin);
            chk("exclusive_pulses", 64'(ok), 64'd1);
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int kind, input logic [31:0] d);
        expq.push_back(word(kind, cyc, d));
    endtask

    function automatic int pick(input logic [NPE-1:0] m);
        for (int k = 0; k < NPE; k++)
            if (m[(model_ptr + k) % NPE]) return (model_ptr + k) % NPE;
        return -1;
    endfunction

    task automatic scramble();
        req_valid = NPE'($urandom);
        req_type  = NPE'($urandom);
        req_len   = {$urandom, $urandom};
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            req_valid = '0;
            req_type  = NPE'($urandom);
            mem_stall = 1'($urandom);
            chk("busy_idle", 64'(busy), 64'd0);
            next_cycle();
        end
    endtask

    // One burst starting in an IDLE cycle; returns in the following IDLE cycle.
    task automatic do_burst(input logic [NPE-1:0] mask, input logic [NPE-1:0] types,
                            input logic [NPE*LW-1:0] lens, input int stall_pct,
                            input int fix_beat, input int fix_len, input int abort_beat);
        int       w;
        logic     ty;
        int       ln;
        int       addr;
        int       stall_left;
        bit       fix_done;
        bit       st;
        w  = pick(mask);
        ty = types[w];
        ln = int'(lens[w*LW +: LW]);
        req_valid = mask;
        req_type  = types;
        req_len   = lens;
        mem_stall = 1'($urandom);
        push(K_READY, 32'(1) << w);
        model_ptr = (w + 1) % NPE;
        next_cycle();
        chk("busy_grant", 64'(busy), 64'd1);
        scramble();
        next_cycle();
        addr       = 0;
        stall_left = 0;
        fix_done   = 1'b0;
        while (addr < ln) begin
            if (addr == abort_beat) begin
                req_valid = '1;
                rst = 1'b1;
                #1;
                chk("reset_outputs_zero", 64'({req_ready, mem_rd_en, mem_rd_type, mem_rd_addr,
                    mem_rd_pe, stream_input_finish, stream_filter_finish, busy}), 64'd0);
                chk("reset_queue_drained", 64'(expq.size()), 64'd0);
                model_ptr = 0;
                next_cycle();
                next_cycle();
                rst = 1'b0;
                return;
            end
            scramble();
            if (stall_left > 0) begin
                st = 1'b1;
                stall_left--;
            end else if (addr == fix_beat && !fix_done && fix_len > 0) begin
                fix_done   = 1'b1;
                st         = 1'b1;
                stall_left = fix_len - 1;
            end else begin
                st = ($urandom_range(0, 99) < stall_pct);
            end
            mem_stall = st;
            if (!st) begin
                push(K_BEAT, {6'd0, 2'(w), 7'd0, ty, 16'(addr)});
                addr++;
            end
            next_cycle();
        end
        scramble();
        mem_stall = 1'($urandom);
        if (ty) push(K_FIN, {24'd0, 4'(1 << w), 4'd0});
        else    push(K_FIN, {24'd0, 4'd0, 4'(1 << w)});
        next_cycle();
    endtask

    function automatic logic [NPE*LW-1:0] lens_one(input int pe, input int len);
        logic [NPE*LW-1:0] l;
        l = {$urandom, $urandom};
        l[pe*LW +: LW] = LW'(len);
        return l;
    endfunction

    initial begin
        logic [NPE*LW-1:0] lens;
        int                ab;
        // Requests are held high during reset and must not be acknowledged.
        req_valid = '1;
        req_len   = {4{16'd3}};
        next_cycle();
        next_cycle();
        chk("reset_state", 64'({req_ready, mem_rd_en, mem_rd_type, mem_rd_addr,
            mem_rd_pe, stream_input_finish, stream_filter_finish, busy}), 64'd0);
        rst = 1'b0;

        // Contention from reset: grants must come out 0,1,2,3.
        for (int i = 0; i < NPE; i++)
            do_burst(4'hF, 4'b1010, {4{16'd2}}, 0, -1, 0, -1);

        // Single filter burst of five beats on PE0.
        idle(2);
        do_burst(4'b0001, 4'b0001, lens_one(0, 5), 0, -1, 0, -1);

        // Zero-length input burst on PE2.
        idle(1);
        do_burst(4'b0100, 4'b0000, lens_one(2, 0), 0, -1, 0, -1);

        // Three-cycle stall at beat 1 of a four-beat burst.
        do_burst(4'b0010, 4'b0010, lens_one(1, 4), 0, 1, 3, -1);

        // Fairness: PE3 joins after PE1's grant and is served before PE1 again.
        do_burst(4'b0010, 4'b1000, lens_one(1, 2), 0, -1, 0, -1);
        do_burst(4'b1010, 4'b1000, {4{16'd1}}, 0, -1, 0, -1);
        do_burst(4'b0010, 4'b1000, lens_one(1, 1), 0, -1, 0, -1);

        // Longer burst with random stalls.
        do_burst(4'b0100, 4'b0100, lens_one(2, 300), 20, -1, 0, -1);

        // Reset at beat 3 of 8, then PE0 must win first.
        do_burst(4'b0001, 4'b0001, lens_one(0, 8), 0, -1, 0, 3);
        do_burst(4'hF, 4'b0101, {4{16'd2}}, 0, -1, 0, -1);

        for (int n = 0; n < 120; n++) begin
            for (int p = 0; p < NPE; p++)
                lens[p*LW +: LW] = LW'($urandom_range(0, 7));
            ab = -1;
            if ($urandom_range(0, 24) == 0) ab = $urandom_range(0, 3);
            do_burst(NPE'($urandom_range(1, 15)), NPE'($urandom), lens, 30, -1, 0, ab);
            if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
        end

        idle(3);
        chk("queue_empty_end", 64'(expq.size()), 64'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
